ldst_mem_ctrl: RTL and testbench

//  Sequences load/store instructions from the execute stage onto the single-ported data memory.
//  - Computes the effective address (EA).
//  - Drives the read/write request with byte strobes and holds the pipeline stalled.
//  - Aligns and sign-extends load data, then issues the GPR write-back with load/store done pulses.
//  - Sits between the EX stage and the data memory; feeds the WB stage and the hazard unit.

---
 rtl/ldst_mem_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_ldst_mem_ctrl.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_mem_ctrl.sv
// ============================================================================
// Module   : ldst_mem_ctrl
// Purpose  : Load/store sequencer between EX and the single-ported data memory.
//            Optional misalignment trap: define LDST_MISALIGN_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ldst_mem_ctrl #(
    parameter int WIDTH       = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             risc_clk,
    input  logic             risc_rst_n,
    input  logic             ldst_req_i,
    input  logic             ldst_is_store_i,
    input  logic [2:0]       ldst_funct3_i,
    input  logic [WIDTH-1:0] ldst_base_addr_i,
    input  logic [11:0]      ldst_offset_i,
    input  logic [WIDTH-1:0] ldst_store_data_i,
    input  logic [4:0]       ldst_rd_addr_i,
    output logic             stall_pipeline_o,
    output logic             data_mem_read_en_o,
    output logic [WIDTH-1:0] data_mem_read_addr_o,
    output logic             data_mem_write_en_o,
    output logic [WIDTH-1:0] data_mem_write_addr_o,
    output logic [WIDTH-1:0] data_mem_write_data_o,
    output logic [3:0]       data_mem_strobe_o,
    input  logic             data_mem_ready_i,
    input  logic             data_mem_rvalid_i,
    input  logic [WIDTH-1:0] data_mem_read_data_i,
    output logic             reg_wr_en_o,
    output logic [4:0]       reg_wr_addr_o,
    output logic [WIDTH-1:0] reg_wr_data_o,
    output logic             load_valid_o,
    output logic             store_valid_o,
    output logic             ldst_err_o
`ifdef LDST_MISALIGN_CHK_EN
    ,
    output logic             misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic             is_store_q;
    logic [2:0]       funct3_q;
    logic [1:0]       ea_lo_q;
    logic [4:0]       rd_q;

    logic [WIDTH-1:0] ea_d;
    logic             legal_d;
    logic             misal_d;
    logic [3:0]       strobe_d;
    logic [WIDTH-1:0] wdata_d;
    logic [7:0]       ld_byte_d;
    logic [15:0]      ld_half_d;
    logic [WIDTH-1:0] ld_result_d;
    logic             timeout_d;

    assign stall_pipeline_o = (state_q == S_IDLE) ? ldst_req_i : 1'b1;
    assign timeout_d        = (cnt_q == C_TO_LAST);

    always_comb begin
        ea_d = ldst_base_addr_i + {{(WIDTH-12){ldst_offset_i[11]}}, ldst_offset_i};

        legal_d = 1'b0;
        case ({ldst_is_store_i, ldst_funct3_i})
            4'b0_000, 4'b0_001, 4'b0_010, 4'b0_100, 4'b0_101: legal_d = 1'b1;
            4'b1_000, 4'b1_001, 4'b1_010:                     legal_d = 1'b1;
            default:                                          legal_d = 1'b0;
        endcase

`ifdef LDST_MISALIGN_CHK_EN
        misal_d = ((ldst_funct3_i[1:0] == 2'b01) && ea_d[0]) ||
                  ((ldst_funct3_i[1:0] == 2'b10) && (ea_d[1:0] != 2'b00));
`else
        misal_d = 1'b0;
`endif

        // Sub-word sizes drop low EA bits, which force-aligns when the trap is off.
        case (ldst_funct3_i[1:0])
            2'b00: begin
                strobe_d = 4'b0001 << ea_d[1:0];
                wdata_d  = {4{ldst_store_data_i[7:0]}};
            end
            2'b01: begin
                strobe_d = 4'b0011 << {ea_d[1], 1'b0};
                wdata_d  = {2{ldst_store_data_i[15:0]}};
            end
            default: begin
                strobe_d = 4'b1111;
                wdata_d  = ldst_store_data_i;
            end
        endcase

        case (ea_lo_q)
            2'b00:   ld_byte_d = data_mem_read_data_i[7:0];
            2'b01:   ld_byte_d = data_mem_read_data_i[15:8];
            2'b10:   ld_byte_d = data_mem_read_data_i[23:16];
            default: ld_byte_d = data_mem_read_data_i[31:24];
        endcase
        ld_half_d = ea_lo_q[1] ? data_mem_read_data_i[31:16] : data_mem_read_data_i[15:0];

        case (funct3_q)
            3'b000:  ld_result_d = {{24{ld_byte_d[7]}}, ld_byte_d};
            3'b001:  ld_result_d = {{16{ld_half_d[15]}}, ld_half_d};
            3'b100:  ld_result_d = {24'h0, ld_byte_d};
            3'b101:  ld_result_d = {16'h0, ld_half_d};
            default: ld_result_d = data_mem_read_data_i;
        endcase
    end

    always_ff @(posedge risc_clk or negedge risc_rst_n) begin
        if (!risc_rst_n) begin
            state_q               <= S_IDLE;
            cnt_q                 <= 8'd0;
            is_store_q            <= 1'b0;
            funct3_q              <= 3'd0;
            ea_lo_q               <= 2'd0;
            rd_q                  <= 5'd0;
            data_mem_read_en_o    <= 1'b0;
            data_mem_read_addr_o  <= '0;
            data_mem_write_en_o   <= 1'b0;
            data_mem_write_addr_o <= '0;
            data_mem_write_data_o <= '0;
            data_mem_strobe_o     <= 4'd0;
            reg_wr_en_o           <= 1'b0;
            reg_wr_addr_o         <= 5'd0;
            reg_wr_data_o         <= '0;
            load_valid_o          <= 1'b0;
            store_valid_o         <= 1'b0;
            ldst_err_o            <= 1'b0;
`ifdef LDST_MISALIGN_CHK_EN
            misalign_o            <= 1'b0;
`endif
        end else begin
            reg_wr_en_o   <= 1'b0;
            load_valid_o  <= 1'b0;
            store_valid_o <= 1'b0;
            ldst_err_o    <= 1'b0;
`ifdef LDST_MISALIGN_CHK_EN
            misalign_o    <= 1'b0;
`endif
            case (state_q)
                S_IDLE: begin
                    if (ldst_req_i) begin
                        is_store_q <= ldst_is_store_i;
                        funct3_q   <= ldst_funct3_i;
                        ea_lo_q    <= ea_d[1:0];
                        rd_q       <= ldst_rd_addr_i;
                        if (!legal_d) begin
                            state_q    <= S_DONE;
                            ldst_err_o <= 1'b1;
                        end else if (misal_d) begin
                            state_q    <= S_DONE;
                            ldst_err_o <= 1'b1;
`ifdef LDST_MISALIGN_CHK_EN
                            misalign_o <= 1'b1;
`endif
                        end else begin
                            state_q               <= S_ISSUE;
                            cnt_q                 <= 8'd0;
                            data_mem_read_en_o    <= ~ldst_is_store_i;
                            data_mem_write_en_o   <= ldst_is_store_i;
                            data_mem_read_addr_o  <= {ea_d[WIDTH-1:2], 2'b00};
                            data_mem_write_addr_o <= {ea_d[WIDTH-1:2], 2'b00};
                            data_mem_write_data_o <= wdata_d;
                            data_mem_strobe_o     <= strobe_d;
                        end
                    end
                end
                S_ISSUE: begin
                    if (data_mem_ready_i) begin
                        data_mem_read_en_o  <= 1'b0;
                        data_mem_write_en_o <= 1'b0;
                        cnt_q               <= 8'd0;
                        if (is_store_q) begin
                            state_q       <= S_DONE;
                            store_valid_o <= 1'b1;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end else if (timeout_d) begin
                        data_mem_read_en_o  <= 1'b0;
                        data_mem_write_en_o <= 1'b0;
                        state_q             <= S_DONE;
                        ldst_err_o          <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                S_WAIT: begin
                    if (data_mem_rvalid_i) begin
                        state_q       <= S_DONE;
                        reg_wr_data_o <= ld_result_d;
                        reg_wr_addr_o <= rd_q;
                        reg_wr_en_o   <= (rd_q != 5'd0);
                        load_valid_o  <= 1'b1;
                    end else if (timeout_d) begin
                        state_q    <= S_DONE;
                        ldst_err_o <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ldst_mem_ctrl.sv
// ============================================================================
// Module   : tb_ldst_mem_ctrl
// Purpose  : Scoreboard bench for ldst_mem_ctrl (TIMEOUT_CYC overridden to 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ldst_mem_ctrl;

    logic        clk, rst_n;
    logic        req, is_store;
    logic [2:0]  f3;
    logic [31:0] base, sdata, rdata;
    logic [11:0] off;
    logic [4:0]  rd;
    logic        ready, rvalid;
    logic        stall, rd_en, wr_en, reg_wen, load_valid, store_valid, err;
    logic [31:0] rd_addr, wr_addr, wr_data, reg_wdata;
    logic [3:0]  strobe;
    logic [4:0]  reg_waddr;
`ifdef LDST_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    typedef struct {
        logic        lv;
        logic        sv;
        logic        er;
        logic        mis;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
    } exp_t;
    exp_t sb[$];

    ldst_mem_ctrl #(.WIDTH(32), .TIMEOUT_CYC(4)) dut (
        .risc_clk              (clk),
        .risc_rst_n            (rst_n),
        .ldst_req_i            (req),
        .ldst_is_store_i       (is_store),
        .ldst_funct3_i         (f3),
        .ldst_base_addr_i      (base),
        .ldst_offset_i         (off),
        .ldst_store_data_i     (sdata),
        .ldst_rd_addr_i        (rd),
        .stall_pipeline_o      (stall),
        .data_mem_read_en_o    (rd_en),
        .data_mem_read_addr_o  (rd_addr),
        .data_mem_write_en_o   (wr_en),
        .data_mem_write_addr_o (wr_addr),
        .data_mem_write_data_o (wr_data),
        .data_mem_strobe_o     (strobe),
        .data_mem_ready_i      (ready),
        .data_mem_rvalid_i     (rvalid),
        .data_mem_read_data_i  (rdata),
        .reg_wr_en_o           (reg_wen),
        .reg_wr_addr_o         (reg_waddr),
        .reg_wr_data_o         (reg_wdata),
        .load_valid_o          (load_valid),
        .store_valid_o         (store_valid),
        .ldst_err_o            (err)
`ifdef LDST_MISALIGN_CHK_EN
        ,
        .misalign_o            (misalign)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t mk(input logic lv, input logic sv, input logic er, input logic mis,
                                input logic wen, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        e.lv = lv; e.sv = sv; e.er = er; e.mis = mis; e.wen = wen; e.wa = wa; e.wd = wd;
        return e;
    endfunction

    // Reference RV32I load extension.
    function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [31:0] ea, input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*ea[1:0] +: 8];
        h = d[16*ea[1] +: 16];
        case (f)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b100:  return {24'h0, b};
            3'b101:  return {16'h0, h};
            default: return d;
        endcase
    endfunction

    // Retirement monitor: every completion pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && (load_valid || store_valid || err)) begin
            total_cnt++;
            if (sb.size() == 0) begin
                $display("FAIL sb_unexpected: got lv=%b sv=%b err=%b, expected no completion", load_valid, store_valid, err);
            end else begin
                exp_t e;
                logic bad;
                e = sb.pop_front();
                bad = ({load_valid, store_valid, err, reg_wen} !== {e.lv, e.sv, e.er, e.wen});
                if (e.wen && reg_waddr !== e.wa) bad = 1'b1;
                if (e.lv && reg_wdata !== e.wd) bad = 1'b1;
`ifdef LDST_MISALIGN_CHK_EN
                if (misalign !== e.mis) bad = 1'b1;
`endif
                if (bad)
                    $display("FAIL sb_retire: got lv=%b sv=%b err=%b wen=%b wa=%0d wd=%h, expected lv=%b sv=%b err=%b wen=%b wa=%0d wd=%h",
                             load_valid, store_valid, err, reg_wen, reg_waddr, reg_wdata,
                             e.lv, e.sv, e.er, e.wen, e.wa, e.wd);
                else
                    pass_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic st, input logic [2:0] f, input logic [31:0] b,
                             input logic [11:0] o, input logic [31:0] d, input logic [4:0] r);
        req = 1'b1; is_store = st; f3 = f; base = b; off = o; sdata = d; rd = r;
    endtask

    // Runs one load with rvalid delayed dly cycles into WAIT; lat is the completion cycle.
    task automatic do_load(input logic [2:0] f, input logic [31:0] b, input logic [11:0] o,
                           input logic [31:0] d, input logic [4:0] r, input int dly,
                           output int lat, output int stalls, output logic en1, output logic [31:0] a1);
        drive_req(1'b0, f, b, o, 32'h0, r);
        ready = 1'b1; rvalid = 1'b0; rdata = d;
        lat = -1; en1 = 1'b0; a1 = '0;
        #1;
        stalls = stall ? 1 : 0;
        for (int c = 1; c <= 40 && lat < 0; c++) begin
            tick();
            req = 1'b0;
            if (c == 1) begin en1 = rd_en; a1 = rd_addr; end
            rvalid = (c >= 2 + dly);
            #1;
            if (stall) stalls++;
            if (load_valid || err) lat = c;
        end
        rvalid = 1'b0;
        tick();
    endtask

    task automatic do_store(input logic [2:0] f, input logic [31:0] b, input logic [11:0] o,
                            input logic [31:0] d, output int lat, output logic [3:0] s1,
                            output logic [31:0] w1, output logic [31:0] a1, output logic en1);
        drive_req(1'b1, f, b, o, d, 5'd0);
        ready = 1'b1; rvalid = 1'b0;
        lat = -1;
        tick();
        req = 1'b0;
        s1 = strobe; w1 = wr_data; a1 = wr_addr; en1 = wr_en;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            if (c > 1) tick();
            if (store_valid || err) lat = c;
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 1'b0; is_store = 1'b0; f3 = 3'd0; base = '0; off = '0; sdata = '0; rd = '0;
        ready = 1'b0; rvalid = 1'b0; rdata = '0;
        tick(); tick();
        total_cnt++;
        if ({stall, rd_en, wr_en, reg_wen, load_valid, store_valid, err} !== 7'd0)
            $display("FAIL reset_ctrl: got %b expected 0000000", {stall, rd_en, wr_en, reg_wen, load_valid, store_valid, err});
        else pass_cnt++;
        total_cnt++;
        if ({rd_addr, wr_addr, wr_data, strobe, reg_waddr, reg_wdata} !== '0)
            $display("FAIL reset_data: got %h expected 0", {rd_addr, wr_addr, wr_data, strobe, reg_waddr, reg_wdata});
        else pass_cnt++;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_store_word();
        int lat; logic [3:0] s; logic [31:0] w, a; logic en;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        do_store(3'b010, 32'h1000, 12'd4, 32'hDEADBEEF, lat, s, w, a, en);
        total_cnt++;
        if ({en, a, s, w} !== {1'b1, 32'h1004, 4'hF, 32'hDEADBEEF})
            $display("FAIL sw_request: got en=%b addr=%h strb=%h data=%h expected en=1 addr=00001004 strb=f data=deadbeef", en, a, s, w);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 2) $display("FAIL sw_latency: got %0d expected 2", lat);
        else pass_cnt++;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL sw_stall_release: got %b expected 0", stall);
        else pass_cnt++;
    endtask

    task automatic test_store_lanes();
        int lat; logic [3:0] s; logic [31:0] w, a; logic en;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        do_store(3'b000, 32'h7000, 12'd2, 32'h11223344, lat, s, w, a, en);
        total_cnt++;
        if ({a, s, w} !== {32'h7000, 4'b0100, 32'h44444444})
            $display("FAIL sb_lane: got addr=%h strb=%b data=%h expected addr=00007000 strb=0100 data=44444444", a, s, w);
        else pass_cnt++;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        do_store(3'b001, 32'h7000, 12'hFFE, 32'h11223344, lat, s, w, a, en);
        total_cnt++;
        if ({a, s, w, lat} !== {32'h6FFC, 4'b1100, 32'h33443344, 32'd2})
            $display("FAIL sh_lane_negoff: got addr=%h strb=%b data=%h lat=%0d expected addr=00006ffc strb=1100 data=33443344 lat=2", a, s, w, lat);
        else pass_cnt++;
    endtask

    task automatic test_load_ext();
        int lat, st; logic en; logic [31:0] a;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, ld_model(3'b000, 32'h2003, 32'h80123456)));
        do_load(3'b000, 32'h2003, 12'd0, 32'h80123456, 5'd5, 0, lat, st, en, a);
        total_cnt++;
        if ({en, a, lat, st} !== {1'b1, 32'h2000, 32'd3, 32'd4})
            $display("FAIL lb_timing: got en=%b addr=%h lat=%0d stalls=%0d expected en=1 addr=00002000 lat=3 stalls=4", en, a, lat, st);
        else pass_cnt++;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, ld_model(3'b100, 32'h2003, 32'h80123456)));
        do_load(3'b100, 32'h2003, 12'd0, 32'h80123456, 5'd5, 0, lat, st, en, a);
        total_cnt++;
        if (lat !== 3) $display("FAIL lbu_latency: got %0d expected 3", lat);
        else pass_cnt++;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd12, ld_model(3'b001, 32'h4002, 32'h8001ABCD)));
        do_load(3'b001, 32'h4000, 12'd2, 32'h8001ABCD, 5'd12, 0, lat, st, en, a);
        total_cnt++;
        if (lat !== 3) $display("FAIL lh_latency: got %0d expected 3", lat);
        else pass_cnt++;
`ifndef LDST_MISALIGN_CHK_EN
        // Force-aligned halfwords: EA[0] is ignored when selecting the lane.
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd6, ld_model(3'b001, 32'h4000, 32'h1234ABCD)));
        do_load(3'b001, 32'h4001, 12'd0, 32'h1234ABCD, 5'd6, 0, lat, st, en, a);
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7, ld_model(3'b101, 32'h4002, 32'h1234ABCD)));
        do_load(3'b101, 32'h4003, 12'd0, 32'h1234ABCD, 5'd7, 0, lat, st, en, a);
        total_cnt++;
        if (a !== 32'h4000) $display("FAIL lhu_addr: got %h expected 00004000", a);
        else pass_cnt++;
`endif
    endtask

    task automatic test_load_rd0_late();
        int lat, st; logic en; logic [31:0] a;
        sb.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'hCAFEF00D));
        do_load(3'b010, 32'h3000, 12'd0, 32'hCAFEF00D, 5'd0, 3, lat, st, en, a);
        total_cnt++;
        if ({lat, st} !== {32'd6, 32'd7})
            $display("FAIL lw_late: got lat=%0d stalls=%0d expected lat=6 stalls=7", lat, st);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int lat, st; logic en; logic [31:0] a;
        logic ok;
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        drive_req(1'b0, 3'b010, 32'h5000, 12'd0, 32'h0, 5'd7);
        ready = 1'b0; rvalid = 1'b0;
        ok = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            tick();
            req = 1'b0;
            if (rd_en !== 1'b1 || rd_addr !== 32'h5000 || err !== 1'b0) ok = 1'b0;
        end
        total_cnt++;
        if (!ok) $display("FAIL to_hold_request: got a dropped or unstable request, expected rd_en=1 addr=00005000 for 4 cycles");
        else pass_cnt++;
        tick();
        total_cnt++;
        if ({err, rd_en} !== 2'b10) $display("FAIL to_issue_err: got err=%b rd_en=%b expected err=1 rd_en=0", err, rd_en);
        else pass_cnt++;
        tick();
        rvalid = 1'b1; ready = 1'b1;
        total_cnt++;
        if (stall !== 1'b0) $display("FAIL to_stall_drop: got %b expected 0", stall);
        else pass_cnt++;
        tick(); tick();
        rvalid = 1'b0;
        total_cnt++;
        if ({load_valid, reg_wen} !== 2'b00) $display("FAIL to_late_rvalid: got lv=%b wen=%b expected 00", load_valid, reg_wen);
        else pass_cnt++;
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        do_load(3'b010, 32'h5100, 12'd0, 32'h0, 5'd8, 1000, lat, st, en, a);
        total_cnt++;
        if (lat !== 6) $display("FAIL to_wait_err: got lat=%0d expected 6", lat);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        drive_req(1'b0, 3'b011, 32'h9000, 12'd0, 32'h0, 5'd3);
        ready = 1'b1;
        tick();
        req = 1'b0;
        total_cnt++;
        if ({err, rd_en, wr_en} !== 3'b100) $display("FAIL illegal_load: got err=%b rd=%b wr=%b expected 100", err, rd_en, wr_en);
        else pass_cnt++;
        tick(); tick();
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0));
        drive_req(1'b1, 3'b100, 32'h9000, 12'd0, 32'h0, 5'd0);
        tick();
        req = 1'b0;
        total_cnt++;
        if ({err, rd_en, wr_en} !== 3'b100) $display("FAIL illegal_store: got err=%b rd=%b wr=%b expected 100", err, rd_en, wr_en);
        else pass_cnt++;
        tick(); tick();
`ifdef LDST_MISALIGN_CHK_EN
        sb.push_back(mk(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0));
        drive_req(1'b0, 3'b001, 32'h6000, 12'd1, 32'h0, 5'd4);
        tick();
        req = 1'b0;
        total_cnt++;
        if ({misalign, err, rd_en} !== 3'b110) $display("FAIL misalign_lh: got mis=%b err=%b rd=%b expected 110", misalign, err, rd_en);
        else pass_cnt++;
        tick(); tick();
`endif
    endtask

    task automatic test_back_to_back();
        logic ok;
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        sb.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
        drive_req(1'b1, 3'b010, 32'hA000, 12'd0, 32'h01020304, 5'd0);
        ready = 1'b1;
        ok = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            tick();
            if (c == 5) req = 1'b0;
            if (store_valid !== (c == 2 || c == 5)) ok = 1'b0;
            if (stall !== (c != 6)) ok = 1'b0;
        end
        total_cnt++;
        if (!ok) $display("FAIL b2b_store: got a store_valid or stall pattern off, expected store_valid in cycles 2,5 and stall through cycle 5");
        else pass_cnt++;
        tick();
    endtask

    task automatic test_reset_in_wait();
        logic ok;
        drive_req(1'b0, 3'b010, 32'h8000, 12'd0, 32'h0, 5'd9);
        ready = 1'b1; rvalid = 1'b0; rdata = 32'h55AA55AA;
        tick();
        req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({stall, rd_en, wr_en, reg_wen, load_valid, store_valid, err, reg_wdata, rd_addr, strobe} !== '0)
            $display("FAIL rst_wait_outputs: got ctl=%b wdata=%h addr=%h expected all 0",
                     {stall, rd_en, wr_en, reg_wen, load_valid, store_valid, err}, reg_wdata, rd_addr);
        else pass_cnt++;
        tick();
        rst_n = 1'b1;
        rvalid = 1'b1;
        ok = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (reg_wen !== 1'b0 || load_valid !== 1'b0) ok = 1'b0;
        end
        rvalid = 1'b0;
        total_cnt++;
        if (!ok) $display("FAIL rst_wait_rvalid: got a writeback after reset, expected none");
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_store_lanes();
        test_load_ext();
        test_load_rd0_late();
        test_timeout();
        test_illegal();
        test_back_to_back();
        test_reset_in_wait();
        tick();
        total_cnt++;
        if (sb.size() != 0) $display("FAIL sb_drain: got %0d pending, expected 0", sb.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

`default_nettype wire
